// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: execute redirect, instruction-memory request/response, IF/OF register.
// master = fetch unit side, slave = environment (execute, imem, operand fetch).
interface fetch_unit_if;
    logic        isBranchTaken;
    logic [31:0] branchPC;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        input  isBranchTaken, branchPC, stall, imem_valid, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr_out, pc_out
    );

    modport slave (
        output isBranchTaken, branchPC, stall, imem_valid, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one outstanding imem request, IF/OF register; instr_valid follows imem_valid by 1 cycle.
// Under stall a response is parked in a skid word and imem_req drops until it drains; redirect overrides stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] skid, skidNext;
    logic [31:0] addrQ, addrNext;
    logic [31:0] instrQ, instrNext;
    logic [31:0] pcOutQ, pcOutNext;
    logic        reqQ, reqNext;
    logic        vldQ, vldNext;
    logic        discard, discardNext;

    logic [31:0] target;
    logic [31:0] pcPlus4;
    logic        redirect;
    logic        slotFree;

    assign target   = {bus.branchPC[31:2], 2'b00};
    assign pcPlus4  = pc + 32'd4;
    assign redirect = bus.isBranchTaken;
    assign slotFree = !vldQ || !bus.stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = WAIT;
            WAIT:    if (bus.imem_valid && !discard && !redirect && !slotFree) stateNext = HOLD;
            HOLD:    if (redirect || !bus.stall) stateNext = WAIT;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        pcNext      = pc;
        skidNext    = skid;
        addrNext    = addrQ;
        reqNext     = reqQ;
        discardNext = discard;
        instrNext   = instrQ;
        pcOutNext   = pcOutQ;
        vldNext     = vldQ && bus.stall;
        if (redirect) begin
            pcNext  = target;
            vldNext = 1'b0;
        end
        case (state)
            IDLE: begin
                reqNext  = 1'b1;
                addrNext = redirect ? target : pc;
            end
            WAIT: begin
                if (bus.imem_valid) begin
                    if (discard) begin
                        // pc already holds the latest redirect target
                        discardNext = 1'b0;
                        addrNext    = redirect ? target : pc;
                    end else if (redirect) begin
                        addrNext = target;
                    end else if (slotFree) begin
                        vldNext   = 1'b1;
                        instrNext = bus.imem_rdata;
                        pcOutNext = pc;
                        pcNext    = pcPlus4;
                        addrNext  = pcPlus4;
                    end else begin
                        skidNext = bus.imem_rdata;
                        reqNext  = 1'b0;
                    end
                end else if (redirect) begin
                    // outstanding request must still complete; its data is dropped
                    discardNext = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    reqNext  = 1'b1;
                    addrNext = target;
                end else if (!bus.stall) begin
                    vldNext   = 1'b1;
                    instrNext = skid;
                    pcOutNext = pc;
                    pcNext    = pcPlus4;
                    reqNext   = 1'b1;
                    addrNext  = pcPlus4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            skid    <= 32'd0;
            addrQ   <= RESET_PC;
            reqQ    <= 1'b0;
            discard <= 1'b0;
            vldQ    <= 1'b0;
            instrQ  <= 32'd0;
            pcOutQ  <= 32'd0;
        end else begin
            pc      <= pcNext;
            skid    <= skidNext;
            addrQ   <= addrNext;
            reqQ    <= reqNext;
            discard <= discardNext;
            vldQ    <= vldNext;
            instrQ  <= instrNext;
            pcOutQ  <= pcOutNext;
        end
    end

    assign bus.imem_req    = reqQ;
    assign bus.imem_addr   = addrQ;
    assign bus.instr_valid = vldQ;
    assign bus.instr_out   = instrQ;
    assign bus.pc_out      = pcOutQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory returning addr^KEY, program-order scoreboard
// plus per-edge protocol expectations derived from the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errCnt = 0;
    int          chkCnt = 0;
    int          delivered = 0;
    int          age = 0;
    int          lat = 0;
    int          latMode = 0;
    logic [31:0] expPc = RST_PC;
    logic        squashed = 1'b0;
    logic        idle = 1'b1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pickLat();
        return (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
    endfunction

    task automatic driveMem();
        bus.imem_valid = !rst && bus.imem_req && (age >= lat);
        bus.imem_rdata = bus.imem_valid ? (bus.imem_addr ^ KEY) : $urandom;
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.isBranchTaken = 1'b0;
        bus.stall = 1'b0;
        #1;
        checkEq("rst_req",   bus.imem_req,    0);
        checkEq("rst_addr",  bus.imem_addr,   RST_PC);
        checkEq("rst_vld",   bus.instr_valid, 0);
        checkEq("rst_instr", bus.instr_out,   0);
        checkEq("rst_pc",    bus.pc_out,      0);
        @(negedge clk);
        rst = 1'b0;
        expPc = RST_PC;
        squashed = 1'b0;
        idle = 1'b1;
        age = 0;
        lat = pickLat();
        driveMem();
    endtask

    // One clock edge, then every expectation implied by what the DUT saw at that edge.
    task automatic tick();
        logic        pReq, pVld, pBr, pStall, pIv, stale;
        logic [31:0] pAddr, pTgt, pPcOut, pInstr;
        pReq = bus.imem_req;   pAddr = bus.imem_addr;  pVld = bus.imem_valid;
        pBr = bus.isBranchTaken; pTgt = {bus.branchPC[31:2], 2'b00};
        pStall = bus.stall;    pIv = bus.instr_valid;
        pPcOut = bus.pc_out;   pInstr = bus.instr_out;
        @(posedge clk);
        @(negedge clk);
        stale = 1'b0;
        if (pVld) begin
            stale = squashed;
            squashed = 1'b0;
        end else if (pReq && pBr) begin
            squashed = 1'b1;
        end
        if (pReq && !pVld) begin
            checkEq("req_stable",  bus.imem_req,  1);
            checkEq("addr_stable", bus.imem_addr, pAddr);
        end
        if (pBr) begin
            checkEq("flush", bus.instr_valid, 0);
            if (!(pReq && !pVld)) begin
                checkEq("redir_req",  bus.imem_req,  1);
                checkEq("redir_addr", bus.imem_addr, pTgt);
            end
            expPc = pTgt;
        end else begin
            if (pVld && stale) begin
                checkEq("drop_req",  bus.imem_req,  1);
                checkEq("drop_addr", bus.imem_addr, expPc);
            end else if (pVld) begin
                if (pIv && pStall) begin
                    checkEq("skid_park", bus.imem_req, 0);
                end else begin
                    checkEq("load_req",   bus.imem_req,    1);
                    checkEq("load_addr",  bus.imem_addr,   pAddr + 32'd4);
                    checkEq("load_vld",   bus.instr_valid, 1);
                    checkEq("load_pc",    bus.pc_out,      pAddr);
                    checkEq("load_instr", bus.instr_out,   pAddr ^ KEY);
                end
            end else if (!pReq) begin
                if (idle) begin
                    checkEq("first_req",  bus.imem_req,  1);
                    checkEq("first_addr", bus.imem_addr, expPc);
                end else if (!pStall) begin
                    checkEq("drain_req",   bus.imem_req,    1);
                    checkEq("drain_addr",  bus.imem_addr,   pAddr + 32'd4);
                    checkEq("drain_pc",    bus.pc_out,      pAddr);
                    checkEq("drain_instr", bus.instr_out,   pAddr ^ KEY);
                end else begin
                    checkEq("hold_req", bus.imem_req, 0);
                end
            end
            if (pIv && pStall) begin
                checkEq("stall_vld",   bus.instr_valid, 1);
                checkEq("stall_pc",    bus.pc_out,      pPcOut);
                checkEq("stall_instr", bus.instr_out,   pInstr);
            end else if (pIv) begin
                checkEq("order_pc",    pPcOut, expPc);
                checkEq("order_instr", pInstr, expPc ^ KEY);
                expPc = expPc + 32'd4;
                delivered++;
            end
        end
        idle = 1'b0;
        if (pVld || !pReq) begin
            age = 0;
            lat = pickLat();
        end else begin
            age++;
        end
        driveMem();
    endtask

    initial begin
        logic [31:0] heldPc, heldInstr;
        logic        seen, found;
        int          base;
        bus.isBranchTaken = 1'b0;
        bus.branchPC = 32'd0;
        bus.stall = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'd0;
        @(negedge clk);
        latMode = 0;
        doReset();

        // sequential fetch from reset
        tick(); checkEq("seq_addr0", bus.imem_addr, 32'h100);
        tick(); checkEq("seq_addr1", bus.imem_addr, 32'h104);
        checkEq("seq_pc0", bus.pc_out, 32'h100);
        checkEq("seq_vld0", bus.instr_valid, 1);
        tick(); checkEq("seq_addr2", bus.imem_addr, 32'h108);
        checkEq("seq_pc1", bus.pc_out, 32'h104);

        // 3-cycle stall while a response lands in the skid
        heldPc = bus.pc_out;
        heldInstr = bus.instr_out;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("skid_req0", bus.imem_req, 0);
            checkEq("skid_held", bus.instr_out, heldInstr);
        end
        bus.stall = 1'b0;
        latMode = 3;
        tick();
        checkEq("skid_pc", bus.pc_out, heldPc + 32'd4);
        checkEq("skid_issue", bus.imem_addr, 32'h10C);

        // redirect one cycle into a latency-3 fetch
        tick();
        bus.isBranchTaken = 1'b1;
        bus.branchPC = 32'h2000;
        tick();
        bus.isBranchTaken = 1'b0;
        seen = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!seen && bus.imem_addr != 32'h10C) begin
                seen = 1'b1;
                checkEq("lat3_next_addr", bus.imem_addr, 32'h2000);
            end
            if (bus.instr_valid) begin
                found = 1'b1;
                checkEq("lat3_first_pc", bus.pc_out, 32'h2000);
            end else begin
                tick();
            end
        end
        checkEq("lat3_arrived", found, 1);

        // redirect coincident with imem_valid and stall
        latMode = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.instr_valid && bus.imem_valid) found = 1'b1;
            else tick();
        end
        checkEq("simul_setup", found, 1);
        bus.stall = 1'b1;
        bus.isBranchTaken = 1'b1;
        bus.branchPC = 32'h3000;
        tick();
        bus.stall = 1'b0;
        bus.isBranchTaken = 1'b0;
        checkEq("simul_vld",  bus.instr_valid, 0);
        checkEq("simul_req",  bus.imem_req,    1);
        checkEq("simul_addr", bus.imem_addr,   32'h3000);
        tick(); tick();

        // misaligned target
        bus.isBranchTaken = 1'b1;
        bus.branchPC = 32'h4003;
        tick();
        bus.isBranchTaken = 1'b0;
        checkEq("misalign_addr", bus.imem_addr, 32'h4000);
        tick(); tick();

        // wrap-around
        bus.isBranchTaken = 1'b1;
        bus.branchPC = 32'hFFFF_FFFC;
        tick();
        bus.isBranchTaken = 1'b0;
        checkEq("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        checkEq("wrap_addr", bus.imem_addr, 32'h0);
        checkEq("wrap_pc0", bus.pc_out, 32'hFFFF_FFFC);
        tick();
        checkEq("wrap_pc1", bus.pc_out, 32'h0);

        // randomized traffic with a reset in the middle
        latMode = -1;
        for (int i = 0; i < 3000; i++) begin
            bus.stall = ($urandom_range(0, 9) < 3);
            bus.isBranchTaken = ($urandom_range(0, 19) == 0);
            bus.branchPC = $urandom;
            if (i == 1500) doReset();
            else tick();
        end
        bus.stall = 1'b0;
        bus.isBranchTaken = 1'b0;

        // sustained throughput with a zero-latency memory
        latMode = 0;
        for (int i = 0; i < 10; i++) tick();
        base = delivered;
        for (int i = 0; i < 20; i++) tick();
        checkEq("throughput", delivered - base, 20);
        checkEq("progress", (delivered > 200) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that consumes the branch-resolution outputs of the execute stage (`isBranchTaken`, `branchPC`). It drives a variable-latency instruction-memory request/response port and holds the PC register. It delivers `{pc, instruction}` pairs through the IF/OF pipeline register under a downstream stall. A taken branch redirects the PC, flushes the IF/OF register and squashes any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk  input  1`: single clock; all state updates on posedge.
- `rst  input  1`: asynchronous, active-high reset.
- `isBranchTaken  input  1`: redirect request from execute, sampled on posedge.
- `branchPC  input  32`: redirect target; bits [1:0] are ignored and treated as 0.
- `stall  input  1`: downstream (operand fetch) cannot accept the IF/OF register this cycle.
- `imem_req  output  1`: fetch request, registered.
- `imem_addr  output  32`: fetch address, registered, word-aligned.
- `imem_valid  input  1`: one-cycle response pulse; legal only while `imem_req`=1, including the first cycle of `imem_req`.
- `imem_rdata  input  32`: instruction word, qualified by `imem_valid`.
- `instr_valid  output  1`: IF/OF register holds a valid instruction.
- `instr_out  output  32`: IF/OF instruction.
- `pc_out  output  32`: PC of `instr_out`.

## Operation
- **Internal state:**
  - `pc`: address of the next instruction to deliver.
  - FSM {IDLE, WAIT, HOLD}.
  - `discard`: one pending squashed response.
  - `skid`: 32-bit buffer.
- **Memory protocol:**
  - At most one request outstanding.
  - `imem_req`/`imem_addr` stay stable from issue until the edge where `imem_valid`=1.
  - The memory cannot be back-pressured; every response must be absorbed.
- **Slot free:** `!instr_valid || !stall`.
- **Redirect** (`isBranchTaken`=1) has priority over every other event, including `stall`:
  - `pc` ← target.
  - `instr_valid` ← 0.
  - `skid` invalidated.
- **IDLE** (after reset only): next edge `imem_req`←1, `imem_addr`←`pc` (or target if redirect) → WAIT.
- **WAIT, `imem_valid`=1, `discard`=0, no redirect:**
  - Slot free: IF/OF ← {`pc`, `imem_rdata`}, `instr_valid`←1, `pc`←`pc`+4, `imem_addr`←`pc`+4, `imem_req` stays 1, remain WAIT.
  - Slot not free: `skid`←`imem_rdata`, `imem_req`←0 → HOLD.
- **WAIT, `imem_valid`=1, `discard`=1:** response dropped, `discard`←0, `imem_addr`←`pc` (or target if redirect in the same cycle), `imem_req` stays 1.
- **WAIT, `imem_valid`=1, `discard`=0, redirect:** response dropped, `imem_addr`←target, `imem_req` stays 1, `discard` stays 0.
- **WAIT, `imem_valid`=0, redirect:**
  - `discard`←1.
  - `imem_addr` unchanged, because the outstanding request must complete.
  - A further redirect while `discard`=1 only updates `pc`.
- **HOLD** (`imem_req`=0):
  - Redirect: `imem_req`←1, `imem_addr`←target → WAIT.
  - Else if `stall`=0: IF/OF ← {`pc`, `skid`}, `pc`←`pc`+4, `imem_req`←1, `imem_addr`←`pc`+4 → WAIT.
- **IF/OF register when no load occurs:**
  - If `stall`=0, `instr_valid`←0 (consumed).
  - If `stall`=1, the register holds its value.
- **PC arithmetic:** `pc`+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 0.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_out`=0, `pc_out`=0; FSM=IDLE, `discard`=0, `pc`=`RESET_PC`.
- **First request:** `imem_req`=1 at the first posedge after `rst` deasserts.
- **Fetch latency:** with a memory returning `imem_valid` in the first request cycle, `instr_valid` rises 1 cycle after `imem_req`. Sustained throughput is 1 instruction/cycle.
- **Redirect:** the IF/OF register is empty the cycle after the redirect edge. The first target instruction appears the cycle after its response, i.e. squashed response latency + target latency.
- **Reset mid-operation:** asynchronous return to reset values. Any in-flight memory response after `rst` falls is not tracked; the memory must itself be reset with `rst`.

## Test plan
- **Reset:** `RESET_PC`=32'h100, zero-latency memory returning `rdata=addr^32'hA5A5_0000`. Expect `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles; `pc_out` follows one cycle later with `instr_valid`=1 and matching `instr_out`.
- **Stall with skid:** assert `stall` for 3 cycles while a response arrives. Expect:
  - `imem_req`=0 and the FSM in HOLD.
  - `instr_out` held for all 3 cycles.
  - After `stall` falls, the skid word is delivered with `pc_out`=prior+4.
  - No instruction lost or duplicated.
- **Redirect during latency-3 fetch:** redirect to 0x2000 one cycle after issuing 0x10C. Expect:
  - `imem_addr` stays 0x10C until its `imem_valid`.
  - That response is dropped.
  - The next `imem_addr` is 0x2000.
  - `instr_valid`=0 until the 0x2000 word arrives.
- **Simultaneous events:** redirect to 0x3000 coincident with `imem_valid` and `stall`=1. Expect `instr_valid`=0 next cycle, the response discarded, and `imem_addr`=0x3000 with `imem_req` staying 1.
- **Misaligned target:** `branchPC`=32'h4003. Expect `imem_addr`=0x4000.
- **Wrap-around:** redirect to 32'hFFFF_FFFC. Expect the next fetch address 0x0000_0000.
